frame_scan: RTL and testbench

FRAME_SCAN -- requirements
Module: frame_scan

---
 rtl/frame_scan_pkg.sv | 28 ++
 rtl/frame_scan_if.sv | 27 ++
 rtl/frame_scan.sv | 160 ++++++++++++++++
 tb/tb_frame_scan.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/frame_scan_pkg.sv
// Shared constants for the frame scanner and its pixel consumers: image geometry,
// RGB444 field positions and the scanner state encoding.
package frame_scan_pkg;

    localparam int c_img_cols    = 80;
    localparam int c_img_rows    = 60;
    localparam int c_nb_img_pxls = 13;
    localparam int c_nb_buf      = 12;

    localparam int c_red_msb = 11;
    localparam int c_grn_msb = 7;
    localparam int c_blu_msb = 3;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_scan  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = c_st_idle,
        ST_SCAN  = c_st_scan,
        ST_DRAIN = c_st_drain
    } scan_state_t;

    function automatic int pxlCount(input int cols, input int rows);
        return cols * rows;
    endfunction

endpackage

// File: rtl/frame_scan_if.sv
// Bundle between the frame scanner (master), the frame-buffer RAM and the
// downstream pixel consumer (slave).
interface frame_scan_if;
    import frame_scan_pkg::*;

    logic                     frame_rdy;
    logic [c_nb_img_pxls-1:0] buf_addr;
    logic [c_nb_buf-1:0]      buf_data;
    logic [c_nb_img_pxls-1:0] proc_addr;
    logic [c_nb_buf-1:0]      orig_pxl;
    logic                     pxl_valid;
    logic                     ln_end;
    logic                     frm_end;
    logic                     busy;
    logic                     frm_drop;

    modport master (
        input  frame_rdy, buf_data,
        output buf_addr, proc_addr, orig_pxl, pxl_valid, ln_end, frm_end, busy, frm_drop
    );

    modport slave (
        output frame_rdy, buf_data,
        input  buf_addr, proc_addr, orig_pxl, pxl_valid, ln_end, frm_end, busy, frm_drop
    );

endinterface

// File: rtl/frame_scan.sv
// Walks the frame buffer once per frame_rdy and streams every pixel with its
// address and line/frame markers, two clocks behind the issued read address.
module frame_scan #(
    parameter int c_img_cols    = frame_scan_pkg::c_img_cols,
    parameter int c_img_rows    = frame_scan_pkg::c_img_rows,
    parameter int c_nb_img_pxls = frame_scan_pkg::c_nb_img_pxls,
    parameter int c_nb_buf      = frame_scan_pkg::c_nb_buf
) (
    input  logic         clk,
    input  logic         rst,
    frame_scan_if.master bus
);
    import frame_scan_pkg::*;

    localparam int c_nb_col  = $clog2(c_img_cols + 1);
    localparam int c_nb_row  = $clog2(c_img_rows + 1);
    localparam int c_nb_pxls = pxlCount(c_img_cols, c_img_rows);

    localparam logic [c_nb_img_pxls-1:0] c_last_addr = c_nb_img_pxls'(c_nb_pxls - 1);
    localparam logic [c_nb_col-1:0]      c_last_col  = c_nb_col'(c_img_cols - 1);
    localparam logic [c_nb_row-1:0]      c_last_row  = c_nb_row'(c_img_rows - 1);

    scan_state_t              state_q,    state_d;
    logic [c_nb_img_pxls-1:0] bufAddr_q,  bufAddr_d;
    logic [c_nb_col-1:0]      colCnt_q,   colCnt_d;
    logic [c_nb_row-1:0]      rowCnt_q,   rowCnt_d;
    logic                     drainCnt_q, drainCnt_d;
    logic                     pend_q,     pend_d;
    logic                     drop_q,     drop_d;
    logic                     busy_q;

    // Stage 1 holds the marker bits of the address whose RAM data arrives next clock.
    logic                     s1Valid_q;
    logic [c_nb_img_pxls-1:0] s1Addr_q;
    logic                     s1Ln_q;
    logic                     s1Frm_q;

    logic                     pxlValid_q;
    logic [c_nb_img_pxls-1:0] procAddr_q;
    logic [c_nb_buf-1:0]      origPxl_q;
    logic                     lnEnd_q;
    logic                     frmEnd_q;

    logic scanning;
    logic atLineEnd;

    assign scanning  = (state_q == ST_SCAN);
    assign atLineEnd = scanning && (colCnt_q == c_last_col);

    always_comb begin
        state_d    = state_q;
        bufAddr_d  = bufAddr_q;
        colCnt_d   = colCnt_q;
        rowCnt_d   = rowCnt_q;
        drainCnt_d = drainCnt_q;
        pend_d     = pend_q;
        drop_d     = drop_q;

        case (state_q)
            ST_IDLE: begin
                bufAddr_d = '0;
                colCnt_d  = '0;
                rowCnt_d  = '0;
                if (bus.frame_rdy || pend_q) begin
                    state_d = ST_SCAN;
                    pend_d  = 1'b0;
                end
            end
            ST_SCAN: begin
                if (bufAddr_q == c_last_addr) begin
                    state_d    = ST_DRAIN;
                    bufAddr_d  = '0;
                    colCnt_d   = '0;
                    rowCnt_d   = '0;
                    drainCnt_d = 1'b0;
                end else begin
                    bufAddr_d = bufAddr_q + c_nb_img_pxls'(1);
                    if (colCnt_q == c_last_col) begin
                        colCnt_d = '0;
                        rowCnt_d = rowCnt_q + c_nb_row'(1);
                    end else begin
                        colCnt_d = colCnt_q + c_nb_col'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drainCnt_q) begin
                    state_d    = ST_IDLE;
                    drainCnt_d = 1'b0;
                end else begin
                    drainCnt_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Only one frame can wait behind the running scan; any further request is lost.
        if (bus.frame_rdy && (state_q != ST_IDLE)) begin
            if (pend_q) begin
                drop_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bufAddr_q  <= '0;
            colCnt_q   <= '0;
            rowCnt_q   <= '0;
            drainCnt_q <= 1'b0;
            pend_q     <= 1'b0;
            drop_q     <= 1'b0;
            busy_q     <= 1'b0;
            s1Valid_q  <= 1'b0;
            s1Addr_q   <= '0;
            s1Ln_q     <= 1'b0;
            s1Frm_q    <= 1'b0;
            pxlValid_q <= 1'b0;
            procAddr_q <= '0;
            origPxl_q  <= '0;
            lnEnd_q    <= 1'b0;
            frmEnd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bufAddr_q  <= bufAddr_d;
            colCnt_q   <= colCnt_d;
            rowCnt_q   <= rowCnt_d;
            drainCnt_q <= drainCnt_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
            busy_q     <= (state_d != ST_IDLE);

            s1Valid_q  <= scanning;
            s1Addr_q   <= scanning ? bufAddr_q : '0;
            s1Ln_q     <= atLineEnd;
            s1Frm_q    <= atLineEnd && (rowCnt_q == c_last_row);

            pxlValid_q <= s1Valid_q;
            procAddr_q <= s1Valid_q ? s1Addr_q : '0;
            origPxl_q  <= s1Valid_q ? bus.buf_data : '0;
            lnEnd_q    <= s1Ln_q;
            frmEnd_q   <= s1Frm_q;
        end
    end

    assign bus.buf_addr  = bufAddr_q;
    assign bus.proc_addr = procAddr_q;
    assign bus.orig_pxl  = origPxl_q;
    assign bus.pxl_valid = pxlValid_q;
    assign bus.ln_end    = lnEnd_q;
    assign bus.frm_end   = frmEnd_q;
    assign bus.busy      = busy_q;
    assign bus.frm_drop  = drop_q;

endmodule

// File: tb/tb_frame_scan.sv
// Directed bench for frame_scan: single frames, a queued frame, dropped
// requests and a mid-frame reset, against a RAM holding mem[a] = a[11:0].
module tb_frame_scan;
    import frame_scan_pkg::*;

    localparam int c_n = c_img_cols * c_img_rows;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    frame_scan_if bus ();

    frame_scan #(
        .c_img_cols    (c_img_cols),
        .c_img_rows    (c_img_rows),
        .c_nb_img_pxls (c_nb_img_pxls),
        .c_nb_buf      (c_nb_buf)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-buffer RAM with one clock of read latency.
    always @(posedge clk) bus.buf_data <= bus.buf_addr[11:0];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(output int latency, output logic [31:0] firstAddr, output logic [31:0] firstBusy);
        bus.frame_rdy = 1'b1;
        latency   = 0;
        firstAddr = 32'hFFFF_FFFF;
        firstBusy = 32'd0;
        do begin
            @(negedge clk);
            latency++;
            if (latency == 1) begin
                bus.frame_rdy = 1'b0;
                firstAddr = 32'(bus.buf_addr);
                firstBusy = 32'(bus.busy);
            end
        end while (!bus.pxl_valid && latency < 20);
        bus.frame_rdy = 1'b0;
    endtask

    task automatic streamFrame(input int stopAt, input int rdyA, input int rdyB,
                               output int errs, output int lnCnt, output int frmCnt);
        errs   = 0;
        lnCnt  = 0;
        frmCnt = 0;
        for (int i = 0; i < c_n; i++) begin
            if (i == stopAt) break;
            if (bus.pxl_valid !== 1'b1) errs++;
            if (bus.proc_addr !== c_nb_img_pxls'(i)) errs++;
            if (bus.orig_pxl !== 12'(i)) errs++;
            if (bus.ln_end !== ((i % c_img_cols) == c_img_cols - 1)) errs++;
            if (bus.frm_end !== (i == c_n - 1)) errs++;
            if (bus.busy !== 1'b1) errs++;
            if (bus.ln_end === 1'b1) lnCnt++;
            if (bus.frm_end === 1'b1) frmCnt++;
            bus.frame_rdy = (i == rdyA) || (i == rdyB);
            @(negedge clk);
        end
        bus.frame_rdy = 1'b0;
    endtask

    task automatic countGap(output int gap);
        gap = 0;
        while (!bus.pxl_valid && gap < 20) begin
            gap++;
            @(negedge clk);
        end
    endtask

    task automatic countQuiet(input int cycles, output int valids, output int frms);
        valids = 0;
        frms   = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.pxl_valid !== 1'b0) valids++;
            if (bus.frm_end !== 1'b0) frms++;
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] fAddr;
        logic [31:0] fBusy;
        int          errs;
        int          lnCnt;
        int          frmCnt;
        int          gap;
        int          valids;
        int          frms;

        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.frame_rdy = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        checkOutput("rst_pxl_valid", 32'(bus.pxl_valid), 32'd0);
        checkOutput("rst_busy",      32'(bus.busy),      32'd0);
        checkOutput("rst_buf_addr",  32'(bus.buf_addr),  32'd0);
        checkOutput("rst_proc_addr", 32'(bus.proc_addr), 32'd0);
        checkOutput("rst_frm_drop",  32'(bus.frm_drop),  32'd0);
        rst = 1'b0;

        countQuiet(5, valids, frms);
        checkOutput("idle_no_valid", 32'(valids), 32'd0);
        checkOutput("idle_buf_addr", 32'(bus.buf_addr), 32'd0);

        $display("[TB] single frame");
        applyStimulus(lat, fAddr, fBusy);
        checkOutput("f1_latency",    32'(lat), 32'd3);
        checkOutput("f1_first_addr", fAddr,    32'd0);
        checkOutput("f1_first_busy", fBusy,    32'd1);
        streamFrame(-1, -1, -1, errs, lnCnt, frmCnt);
        checkOutput("f1_pixel_errs", 32'(errs),   32'd0);
        checkOutput("f1_ln_count",   32'(lnCnt),  32'd60);
        checkOutput("f1_frm_count",  32'(frmCnt), 32'd1);
        checkOutput("f1_busy_after", 32'(bus.busy), 32'd0);
        checkOutput("f1_valid_after", 32'(bus.pxl_valid), 32'd0);
        countQuiet(10, valids, frms);
        checkOutput("f1_no_extra", 32'(valids), 32'd0);

        $display("[TB] queued frame");
        applyStimulus(lat, fAddr, fBusy);
        checkOutput("q_latency", 32'(lat), 32'd3);
        streamFrame(-1, 1000, -1, errs, lnCnt, frmCnt);
        checkOutput("q_f1_errs", 32'(errs), 32'd0);
        countGap(gap);
        checkOutput("q_gap",        32'(gap), 32'd3);
        checkOutput("q_drop_clear", 32'(bus.frm_drop), 32'd0);
        streamFrame(-1, -1, -1, errs, lnCnt, frmCnt);
        checkOutput("q_f2_errs",  32'(errs),   32'd0);
        checkOutput("q_f2_frm",   32'(frmCnt), 32'd1);
        countQuiet(10, valids, frms);
        checkOutput("q_no_third", 32'(valids), 32'd0);
        checkOutput("q_drop_end", 32'(bus.frm_drop), 32'd0);

        $display("[TB] overflow of request queue");
        applyStimulus(lat, fAddr, fBusy);
        streamFrame(-1, 500, 1500, errs, lnCnt, frmCnt);
        checkOutput("d_f1_errs", 32'(errs), 32'd0);
        checkOutput("d_drop_set", 32'(bus.frm_drop), 32'd1);
        countGap(gap);
        checkOutput("d_gap", 32'(gap), 32'd3);
        streamFrame(-1, -1, -1, errs, lnCnt, frmCnt);
        checkOutput("d_f2_errs", 32'(errs), 32'd0);
        countQuiet(20, valids, frms);
        checkOutput("d_one_extra", 32'(valids), 32'd0);
        checkOutput("d_drop_sticky", 32'(bus.frm_drop), 32'd1);

        $display("[TB] reset mid-frame");
        applyStimulus(lat, fAddr, fBusy);
        streamFrame(2000, -1, -1, errs, lnCnt, frmCnt);
        checkOutput("r_pre_errs",  32'(errs), 32'd0);
        checkOutput("r_pre_valid", 32'(bus.pxl_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("r_async_valid", 32'(bus.pxl_valid), 32'd0);
        checkOutput("r_async_addr",  32'(bus.proc_addr), 32'd0);
        checkOutput("r_async_pxl",   32'(bus.orig_pxl),  32'd0);
        checkOutput("r_async_busy",  32'(bus.busy),      32'd0);
        checkOutput("r_async_baddr", 32'(bus.buf_addr),  32'd0);
        checkOutput("r_async_drop",  32'(bus.frm_drop),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        countQuiet(10, valids, frms);
        checkOutput("r_quiet_valid", 32'(valids), 32'd0);
        checkOutput("r_quiet_frm",   32'(frms),   32'd0);
        applyStimulus(lat, fAddr, fBusy);
        checkOutput("r_latency",    32'(lat),   32'd3);
        checkOutput("r_first_addr", fAddr,      32'd0);
        streamFrame(-1, -1, -1, errs, lnCnt, frmCnt);
        checkOutput("r_f_errs", 32'(errs),   32'd0);
        checkOutput("r_f_frm",  32'(frmCnt), 32'd1);
        checkOutput("r_f_ln",   32'(lnCnt),  32'd60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
